// File: rtl/uart_flow.sv
// uart_flow: UART transceiver with RX/TX FIFOs and RTS/CTS hardware flow control.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   baud_div            baud tick period minus one (tick every baud_div+1 clk)
//   parity_mode         0 none, 1 odd, 2 even, 3 none
//   stop2               two stop bits when set
//   rx / tx             serial input / output
//   cts_n / rts_n       flow control in (gates TX frame starts) / out (RX FIFO nearly full)
//   tx_data, wr_en      TX FIFO push side; tx_full, tx_count report occupancy
//   rx_data, rd_en      RX FIFO pop side (first-word fall-through); rx_empty, rx_count
//   tx_busy             transmitter is mid-frame
//   parity_err, frame_err, overrun_err, break_det   sticky flags, cleared by err_clr

// Synchronous FIFO, first-word fall-through. Head reads as 0 when empty.
module uart_flow_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_DEPTH);
        do_pop   = pop && !empty;
        // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rdata    = empty ? '0 : mem[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module uart_flow #(
    parameter int DATA_BITS    = 8,
    parameter int RX_ADDR_BITS = 3,
    parameter int TX_ADDR_BITS = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_BITS     = 16,
    parameter int RTS_MARGIN   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DIV_BITS-1:0]     baud_div,
    input  logic [1:0]              parity_mode,
    input  logic                    stop2,
    input  logic                    rx,
    input  logic                    cts_n,
    input  logic [DATA_BITS-1:0]    tx_data,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic                    tx,
    output logic                    rts_n,
    output logic [DATA_BITS-1:0]    rx_data,
    output logic                    rx_empty,
    output logic                    tx_full,
    output logic [RX_ADDR_BITS:0]   rx_count,
    output logic [TX_ADDR_BITS:0]   tx_count,
    output logic                    tx_busy,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overrun_err,
    output logic                    break_det
);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [OS_W-1:0]     OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]     OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]     OS_ONE    = OS_W'(1);
    localparam logic [BIT_W-1:0]    DBIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]    BIT_ONE   = BIT_W'(1);
    localparam logic [DIV_BITS-1:0] DIV_ONE   = DIV_BITS'(1);
    localparam logic [RX_ADDR_BITS:0] RTS_LEVEL =
        (RX_ADDR_BITS+1)'((1 << RX_ADDR_BITS) - RTS_MARGIN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // ---------------- baud tick ----------------
    // The divisor is captured at each reload so a new baud_div never truncates a running period.
    logic [DIV_BITS-1:0] baud_cnt_q, baud_cnt_d, div_q, div_d;
    logic                tick;

    always_comb begin
        tick       = (baud_cnt_q == div_q);
        baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_ONE;
        div_d      = tick ? baud_div : div_q;
    end

    // ---------------- input synchronisers ----------------
    logic [1:0] rx_sync_q, rx_sync_d, cts_sync_q, cts_sync_d;
    logic       rx_s, cts_s;

    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rx};
        cts_sync_d = {cts_sync_q[0], cts_n};
        rx_s       = rx_sync_q[1];
        cts_s      = cts_sync_q[1];
    end

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty, tx_pop, rx_full;
    logic                 rx_push_q;
    logic [DATA_BITS-1:0] rx_push_data_q;

    uart_flow_fifo #(.W(DATA_BITS), .AW(TX_ADDR_BITS)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(wr_en), .pop(tx_pop), .wdata(tx_data),
        .rdata(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full)
    );

    uart_flow_fifo #(.W(DATA_BITS), .AW(RX_ADDR_BITS)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push_q), .pop(rd_en), .wdata(rx_push_data_q),
        .rdata(rx_data), .count(rx_count), .empty(rx_empty), .full(rx_full)
    );

    // ---------------- transmitter ----------------
    state_e               tx_state_q;
    logic                 tx_q;
    logic [OS_W-1:0]      tx_os_q;
    logic [BIT_W-1:0]     tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_en_q, tx_par_bit_q, tx_stop2_q, tx_stop_idx_q;
    logic                 tx_last;

    always_comb begin
        // Final tick of the final stop bit: a queued frame may start right here, giving
        // back-to-back frames with no idle gap.
        tx_last = (tx_state_q == S_STOP) && (tx_os_q == OS_LAST) && (!tx_stop2_q || tx_stop_idx_q);
        tx_pop  = tick && !tx_empty && !cts_s && ((tx_state_q == S_IDLE) || tx_last);
        tx      = tx_q;
        tx_busy = (tx_state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q    <= S_IDLE;
            tx_q          <= 1'b1;
            tx_os_q       <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_en_q   <= 1'b0;
            tx_par_bit_q  <= 1'b0;
            tx_stop2_q    <= 1'b0;
            tx_stop_idx_q <= 1'b0;
        end else if (tx_pop) begin
            tx_state_q    <= S_START;
            tx_q          <= 1'b0;
            tx_os_q       <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= tx_head;
            tx_par_en_q   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
            // Even parity repeats the XOR of the data; odd parity inverts it.
            tx_par_bit_q  <= (^tx_head) ^ (parity_mode == 2'd1);
            tx_stop2_q    <= stop2;
            tx_stop_idx_q <= 1'b0;
        end else if (tick && tx_state_q != S_IDLE) begin
            if (tx_os_q != OS_LAST) begin
                tx_os_q <= tx_os_q + OS_ONE;
            end else begin
                tx_os_q <= '0;
                case (tx_state_q)
                    S_START: begin
                        tx_state_q <= S_DATA;
                        tx_q       <= tx_shift_q[0];
                    end
                    S_DATA: begin
                        if (tx_bit_q == DBIT_LAST) begin
                            tx_state_q <= tx_par_en_q ? S_PARITY : S_STOP;
                            tx_q       <= tx_par_en_q ? tx_par_bit_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + BIT_ONE;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end
                    S_STOP: begin
                        if (tx_stop2_q && !tx_stop_idx_q) tx_stop_idx_q <= 1'b1;
                        else tx_state_q <= S_IDLE;
                    end
                    default: begin
                        tx_state_q <= S_IDLE;
                        tx_q       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    state_e               rx_state_q;
    logic                 rx_armed_q;
    logic [OS_W-1:0]      rx_os_q;
    logic [BIT_W-1:0]     rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_en_q, rx_par_odd_q, rx_par_q;
    logic                 rx_perr_ev_q, rx_ferr_ev_q, rx_brk_ev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q     <= S_IDLE;
            rx_armed_q     <= 1'b0;
            rx_os_q        <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_par_en_q    <= 1'b0;
            rx_par_odd_q   <= 1'b0;
            rx_par_q       <= 1'b0;
            rx_push_q      <= 1'b0;
            rx_push_data_q <= '0;
            rx_perr_ev_q   <= 1'b0;
            rx_ferr_ev_q   <= 1'b0;
            rx_brk_ev_q    <= 1'b0;
        end else begin
            rx_push_q    <= 1'b0;
            rx_perr_ev_q <= 1'b0;
            rx_ferr_ev_q <= 1'b0;
            rx_brk_ev_q  <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    // A start bit is accepted only after the line has been seen high,
                    // so a held-low break is not re-read as a stream of frames.
                    if (rx_s) begin
                        rx_armed_q <= 1'b1;
                    end else if (rx_armed_q) begin
                        rx_armed_q   <= 1'b0;
                        rx_state_q   <= S_START;
                        rx_os_q      <= '0;
                        rx_par_en_q  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                        rx_par_odd_q <= (parity_mode == 2'd1);
                    end
                end
                S_START: if (tick) begin
                    if (rx_os_q != OS_HALF) begin
                        rx_os_q <= rx_os_q + OS_ONE;
                    end else begin
                        // Mid-start-bit check; a high line here was a glitch.
                        rx_os_q    <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    if (rx_os_q != OS_LAST) begin
                        rx_os_q <= rx_os_q + OS_ONE;
                    end else begin
                        rx_os_q    <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DBIT_LAST) rx_state_q <= rx_par_en_q ? S_PARITY : S_STOP;
                        else rx_bit_q <= rx_bit_q + BIT_ONE;
                    end
                end
                S_PARITY: if (tick) begin
                    if (rx_os_q != OS_LAST) begin
                        rx_os_q <= rx_os_q + OS_ONE;
                    end else begin
                        rx_os_q    <= '0;
                        rx_par_q   <= rx_s;
                        rx_state_q <= S_STOP;
                    end
                end
                S_STOP: if (tick) begin
                    if (rx_os_q != OS_LAST) begin
                        rx_os_q <= rx_os_q + OS_ONE;
                    end else begin
                        rx_os_q    <= '0;
                        rx_state_q <= S_IDLE;
                        if (!rx_s) begin
                            if (rx_shift_q == '0) rx_brk_ev_q  <= 1'b1;
                            else                  rx_ferr_ev_q <= 1'b1;
                        end else begin
                            rx_push_q      <= 1'b1;
                            rx_push_data_q <= rx_shift_q;
                            if (rx_par_en_q && (rx_par_q != ((^rx_shift_q) ^ rx_par_odd_q)))
                                rx_perr_ev_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- sticky flags and RTS ----------------
    logic parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic overrun_err_q, overrun_err_d, break_det_q, break_det_d;
    logic rts_n_q, rts_n_d, overrun_ev;

    always_comb begin
        // A pop in the same cycle makes room, so that push is not an overrun.
        overrun_ev    = rx_push_q && rx_full && !rd_en;
        parity_err_d  = rx_perr_ev_q | (parity_err_q  & ~err_clr);
        frame_err_d   = rx_ferr_ev_q | (frame_err_q   & ~err_clr);
        overrun_err_d = overrun_ev   | (overrun_err_q & ~err_clr);
        break_det_d   = rx_brk_ev_q  | (break_det_q   & ~err_clr);
        rts_n_d       = (rx_count >= RTS_LEVEL);
        parity_err    = parity_err_q;
        frame_err     = frame_err_q;
        overrun_err   = overrun_err_q;
        break_det     = break_det_q;
        rts_n         = rts_n_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q    <= '0;
            div_q         <= '0;
            rx_sync_q     <= 2'b11;
            cts_sync_q    <= 2'b11;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            break_det_q   <= 1'b0;
            rts_n_q       <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            div_q         <= div_d;
            rx_sync_q     <= rx_sync_d;
            cts_sync_q    <= cts_sync_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            break_det_q   <= break_det_d;
            rts_n_q       <= rts_n_d;
        end
    end
endmodule

// File: tb/tb_uart_flow.sv
// Directed testbench for uart_flow: reset state, TX framing, loopback, RTS/overrun,
// RX error detection, CTS gating and reset mid-frame.
module tb_uart_flow;
    logic        clk, reset_n;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2, rx, cts_n, wr_en, rd_en, err_clr;
    logic [7:0]  tx_data, rx_data;
    logic        tx, rts_n, rx_empty, tx_full, tx_busy;
    logic        parity_err, frame_err, overrun_err, break_det;
    logic [3:0]  rx_count;
    logic [4:0]  tx_count;
    logic        loop_en, rx_drv;
    int          n_checks, n_fail;

    assign rx = loop_en ? tx : rx_drv;

    uart_flow dut (
        .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
        .stop2(stop2), .rx(rx), .cts_n(cts_n), .tx_data(tx_data), .wr_en(wr_en),
        .rd_en(rd_en), .err_clr(err_clr), .tx(tx), .rts_n(rts_n), .rx_data(rx_data),
        .rx_empty(rx_empty), .tx_full(tx_full), .rx_count(rx_count), .tx_count(tx_count),
        .tx_busy(tx_busy), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .break_det(break_det)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Drive n bits (index 0 first) onto rx, 16 clk each at baud_div=0.
    task automatic send_frame(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            clks(16);
        end
        rx_drv = 1'b1;
        clks(40);
    endtask

    task automatic test_reset();
        reset_n = 1'b1; baud_div = 16'd0; parity_mode = 2'd0; stop2 = 1'b0;
        cts_n = 1'b0; tx_data = 8'h00; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        loop_en = 1'b0; rx_drv = 1'b1;
        #2 reset_n = 1'b0;
        clks(3);
        n_checks++;
        if ({tx, rts_n, rx_empty, tx_full, tx_busy} !== 5'b10100) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 10100", {tx, rts_n, rx_empty, tx_full, tx_busy});
        end
        n_checks++;
        if ({parity_err, frame_err, overrun_err, break_det} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {parity_err, frame_err, overrun_err, break_det});
        end
        n_checks++;
        if (rx_count !== 4'd0 || tx_count !== 5'd0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_counts: rx_count=%0d tx_count=%0d rx_data=%h want 0/0/00", rx_count, tx_count, rx_data);
        end
        reset_n = 1'b1;
        clks(5);
    endtask

    task automatic test_tx_frame();
        logic [10:0] exp;
        int t;
        baud_div = 16'd2; parity_mode = 2'd2; stop2 = 1'b0; cts_n = 1'b0;
        clks(10);
        exp = {1'b1, 1'b0, 8'hA5, 1'b0};
        push(8'hA5);
        t = 0;
        while (tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL tx_start_timeout: tx=%b want 0", tx); end
        for (int k = 0; k < 11; k++) begin
            clks(1);
            n_checks++;
            if (tx !== exp[k] || tx_busy !== 1'b1) begin
                n_fail++; $display("FAIL tx_bit%0d_early: tx=%b busy=%b want %b/1", k, tx, tx_busy, exp[k]);
            end
            clks(45);
            n_checks++;
            if (tx !== exp[k] || tx_busy !== 1'b1) begin
                n_fail++; $display("FAIL tx_bit%0d_late: tx=%b busy=%b want %b/1", k, tx, tx_busy, exp[k]);
            end
            clks(2);
        end
        n_checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL tx_idle_after: tx=%b busy=%b want 1/0", tx, tx_busy);
        end
    endtask

    task automatic test_loopback();
        logic [23:0] exp;
        int t;
        baud_div = 16'd0; parity_mode = 2'd1; stop2 = 1'b1; loop_en = 1'b1;
        clks(10);
        exp = {8'h5A, 8'hFF, 8'h00};
        push(8'h00); push(8'hFF); push(8'h5A);
        t = 0;
        while (rx_count !== 4'd3 && t < 3000) begin @(negedge clk); t++; end
        clks(2);
        n_checks++;
        if (rx_count !== 4'd3) begin n_fail++; $display("FAIL loop_count: got %0d want 3", rx_count); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx_data !== exp[i*8 +: 8]) begin
                n_fail++; $display("FAIL loop_data%0d: got %h want %h", i, rx_data, exp[i*8 +: 8]);
            end
            pop();
        end
        n_checks++;
        if (rx_empty !== 1'b1 || {parity_err, frame_err, overrun_err, break_det} !== 4'b0000) begin
            n_fail++; $display("FAIL loop_flags: empty=%b flags=%b want 1/0000", rx_empty, {parity_err, frame_err, overrun_err, break_det});
        end
    endtask

    task automatic test_rts_overrun();
        int t;
        baud_div = 16'd0; parity_mode = 2'd0; stop2 = 1'b0; loop_en = 1'b1;
        clks(20);
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        t = 0;
        while (rx_count !== 4'd5 && t < 2000) begin @(negedge clk); t++; end
        clks(2);
        n_checks++;
        if (rx_count !== 4'd5 || rts_n !== 1'b0) begin
            n_fail++; $display("FAIL rts_at5: count=%0d rts_n=%b want 5/0", rx_count, rts_n);
        end
        t = 0;
        while (rx_count !== 4'd6 && t < 1000) begin @(negedge clk); t++; end
        clks(2);
        n_checks++;
        if (rx_count !== 4'd6 || rts_n !== 1'b1) begin
            n_fail++; $display("FAIL rts_at6: count=%0d rts_n=%b want 6/1", rx_count, rts_n);
        end
        for (int i = 6; i < 9; i++) push(8'(8'h10 + i));
        t = 0;
        while ((tx_busy !== 1'b0 || tx_count !== 5'd0) && t < 3000) begin @(negedge clk); t++; end
        clks(50);
        n_checks++;
        if (rx_count !== 4'd8 || overrun_err !== 1'b1 || rts_n !== 1'b1) begin
            n_fail++; $display("FAIL overrun: count=%0d ovr=%b rts_n=%b want 8/1/1", rx_count, overrun_err, rts_n);
        end
        n_checks++;
        if (rx_data !== 8'h10) begin n_fail++; $display("FAIL ovr_head: got %h want 10", rx_data); end
        pop();
        clks(2);
        n_checks++;
        if (rx_count !== 4'd7 || rts_n !== 1'b1) begin
            n_fail++; $display("FAIL rts_at7: count=%0d rts_n=%b want 7/1", rx_count, rts_n);
        end
        pop(); pop();
        clks(2);
        n_checks++;
        if (rx_count !== 4'd5 || rts_n !== 1'b0) begin
            n_fail++; $display("FAIL rts_release: count=%0d rts_n=%b want 5/0", rx_count, rts_n);
        end
        for (int i = 3; i < 8; i++) begin
            n_checks++;
            if (rx_data !== 8'(8'h10 + i)) begin
                n_fail++; $display("FAIL ovr_data%0d: got %h want %h", i, rx_data, 8'(8'h10 + i));
            end
            pop();
        end
        n_checks++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drain: empty=%b want 1", rx_empty); end
    endtask

    task automatic test_rx_errors();
        loop_en = 1'b0; rx_drv = 1'b1; parity_mode = 2'd0; stop2 = 1'b0; baud_div = 16'd0;
        err_clr = 1'b1; clks(1); err_clr = 1'b0; clks(2);
        n_checks++;
        if ({parity_err, frame_err, overrun_err, break_det} !== 4'b0000) begin
            n_fail++; $display("FAIL clr_overrun: flags=%b want 0000", {parity_err, frame_err, overrun_err, break_det});
        end
        rx_drv = 1'b0; clks(4); rx_drv = 1'b1; clks(40);
        n_checks++;
        if (rx_count !== 4'd0 || {parity_err, frame_err, overrun_err, break_det} !== 4'b0000) begin
            n_fail++; $display("FAIL glitch: count=%0d flags=%b want 0/0000", rx_count, {parity_err, frame_err, overrun_err, break_det});
        end
        send_frame({1'b1, 1'b0, 8'h33, 1'b0}, 10);
        n_checks++;
        if (frame_err !== 1'b1 || break_det !== 1'b0 || rx_count !== 4'd0) begin
            n_fail++; $display("FAIL frame_err: fe=%b brk=%b count=%0d want 1/0/0", frame_err, break_det, rx_count);
        end
        send_frame(11'd0, 10);
        n_checks++;
        if (break_det !== 1'b1 || rx_count !== 4'd0) begin
            n_fail++; $display("FAIL break: brk=%b count=%0d want 1/0", break_det, rx_count);
        end
        parity_mode = 2'd2;
        clks(2);
        send_frame({1'b1, 1'b1, 8'h33, 1'b0}, 11);
        n_checks++;
        if (parity_err !== 1'b1 || rx_count !== 4'd1 || rx_data !== 8'h33) begin
            n_fail++; $display("FAIL parity_err: pe=%b count=%0d data=%h want 1/1/33", parity_err, rx_count, rx_data);
        end
        pop();
        err_clr = 1'b1; clks(1); err_clr = 1'b0; clks(1);
        n_checks++;
        if ({parity_err, frame_err, overrun_err, break_det} !== 4'b0000) begin
            n_fail++; $display("FAIL err_clr: flags=%b want 0000", {parity_err, frame_err, overrun_err, break_det});
        end
        parity_mode = 2'd0;
    endtask

    task automatic test_cts();
        int t, cnt;
        bit low_seen;
        loop_en = 1'b0; rx_drv = 1'b1; baud_div = 16'd0; parity_mode = 2'd0; stop2 = 1'b0;
        cts_n = 1'b1; clks(5);
        push(8'h81); push(8'h42);
        low_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1) low_seen = 1'b1;
            clks(1);
        end
        n_checks++;
        if (low_seen || tx_count !== 5'd2) begin
            n_fail++; $display("FAIL cts_hold: low_seen=%b tx_count=%0d want 0/2", low_seen, tx_count);
        end
        cts_n = 1'b0;
        t = 0;
        while (tx_busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        cnt = 0;
        while (tx_busy === 1'b1 && cnt < 1000) begin cnt++; clks(1); end
        n_checks++;
        if (cnt !== 320 || tx_count !== 5'd0) begin
            n_fail++; $display("FAIL cts_b2b: busy_clks=%0d tx_count=%0d want 320/0", cnt, tx_count);
        end
        push(8'hC3); push(8'h3C);
        t = 0;
        while (tx_busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        cnt = 0;
        while (tx_busy === 1'b1 && cnt < 1000) begin
            if (cnt == 80) cts_n = 1'b1;
            cnt++; clks(1);
        end
        clks(100);
        n_checks++;
        if (cnt !== 160 || tx_count !== 5'd1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL cts_mid: busy_clks=%0d tx_count=%0d tx=%b busy=%b want 160/1/1/0", cnt, tx_count, tx, tx_busy);
        end
        cts_n = 1'b0;
        t = 0;
        while ((tx_count !== 5'd0 || tx_busy !== 1'b0) && t < 500) begin @(negedge clk); t++; end
        n_checks++;
        if (tx_count !== 5'd0 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL cts_drain: tx_count=%0d busy=%b want 0/0", tx_count, tx_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        int t;
        baud_div = 16'd0; cts_n = 1'b1; clks(5);
        for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
        n_checks++;
        if (tx_full !== 1'b1 || tx_count !== 5'd16) begin
            n_fail++; $display("FAIL tx_full: full=%b count=%0d want 1/16", tx_full, tx_count);
        end
        cts_n = 1'b0;
        t = 0;
        while (tx_busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        clks(50);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || tx_count !== 5'd0 || tx_busy !== 1'b0 || tx_full !== 1'b0 || rx_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: tx=%b count=%0d busy=%b full=%b rx_empty=%b want 1/0/0/0/1", tx, tx_count, tx_busy, tx_full, rx_empty);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clks(5);
        n_checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_quiet: tx=%b busy=%b want 1/0", tx, tx_busy);
        end
        exp = {1'b1, 8'h3C, 1'b0};
        push(8'h3C);
        t = 0;
        while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        clks(8);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (tx !== exp[k]) begin n_fail++; $display("FAIL restart_bit%0d: tx=%b want %b", k, tx, exp[k]); end
            clks(16);
        end
        n_checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL restart_idle: busy=%b tx=%b want 0/1", tx_busy, tx);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_tx_frame();
        test_loopback();
        test_rts_overrun();
        test_rx_errors();
        test_cts();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
